// File: rtl/clk_mux_seq_pkg.sv
// Shared types and helpers for the clock-source select sequencer:
// state encoding, lowest-healthy-source picker and configuration checks.
package clk_mux_seq_pkg;

  localparam int MAX_CLK = 16;
  localparam int IDX_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GATE_OFF = 2'd1,
    ST_SETTLE   = 2'd2,
    ST_HOLD     = 2'd3
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Lowest set bit wins so that failover always lands on a deterministic source.
  function automatic pick_t lowest_ok(input logic [MAX_CLK-1:0] vec);
    pick_t r;
    r = '0;
    for (int i = MAX_CLK - 1; i >= 0; i--) begin
      if (vec[i]) begin
        r.found = 1'b1;
        r.idx   = IDX_W'(i);
      end
    end
    return r;
  endfunction

  function automatic bit cfg_ok(input int n_clk, input int off_cyc, input int settle_cyc,
                                input int cnt_w, input int rst_sel, input int auto_fo);
    bit ok;
    ok = (n_clk >= 2) && (n_clk <= MAX_CLK);
    ok = ok && (off_cyc >= 1) && (settle_cyc >= 1);
    ok = ok && (cnt_w >= 1) && (cnt_w <= 30);
    ok = ok && (off_cyc < (1 << cnt_w)) && (settle_cyc < (1 << cnt_w));
    ok = ok && (rst_sel >= 0) && (rst_sel < n_clk);
    ok = ok && ((auto_fo == 0) || (auto_fo == 1));
    return ok;
  endfunction

endpackage

// File: rtl/clk_mux_seq_tmr.sv
// Load/decrement timer shared by the gate-off and settle phases; expire is
// high for the single cycle in which the count reaches its last tick.
module clk_mux_seq_tmr #(
  parameter int CNT_W   = 8,
  parameter int RST_VAL = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             run,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (run && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= CNT_W'(RST_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = run && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/clk_mux_seq.sv
// Clock-source select sequencer: gates the muxed clock, waits a dead time,
// moves the mux select, waits for settling and re-enables; fails over on loss.
module clk_mux_seq
  import clk_mux_seq_pkg::*;
#(
  parameter int N_CLK         = 4,
  parameter int OFF_CYC       = 8,
  parameter int SETTLE_CYC    = 16,
  parameter int CNT_W         = 8,
  parameter int AUTO_FAILOVER = 1,
  parameter int RST_SEL       = 0,
  localparam int SEL_W        = $clog2(N_CLK)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  input  logic [SEL_W-1:0] req_sel,
  output logic             req_ready,
  input  logic [N_CLK-1:0] ck_ok,
  output logic [SEL_W-1:0] sel_out,
  output logic             ce_out,
  output logic             busy,
  output logic             done,
  output logic             rej,
  output logic             fail
);

  localparam logic [CNT_W-1:0] OFF_LD    = CNT_W'(OFF_CYC);
  localparam logic [CNT_W-1:0] SET_LD    = CNT_W'(SETTLE_CYC);
  localparam logic [SEL_W-1:0] RST_SEL_V = SEL_W'(RST_SEL);
  localparam bit               AUTO      = (AUTO_FAILOVER != 0);

  if (!cfg_ok(N_CLK, OFF_CYC, SETTLE_CYC, CNT_W, RST_SEL, AUTO_FAILOVER)) begin : g_cfg_err
    $error("clk_mux_seq: illegal parameter combination");
  end

  // Health lookup that also rejects indices beyond N_CLK for non-power-of-two counts.
  function automatic logic src_ok(input logic [SEL_W-1:0] s, input logic [N_CLK-1:0] ok);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_CLK; i++) begin
      if (int'(s) == i) r = ok[i];
    end
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] tgt_q, tgt_d;
  logic             ce_q, ce_d;
  logic             busy_q, busy_d;
  logic             rdy_q, rdy_d;
  logic             done_q, done_d;
  logic             rej_q, rej_d;
  logic             fail_q, fail_d;

  logic [MAX_CLK-1:0] ck_vec;
  pick_t              pick;
  logic               cur_ok;
  logic               tgt_ok;
  logic               req_ok;
  logic               fo_now;
  logic               accept;
  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_val;
  logic               tmr_run;
  logic               tmr_exp;

  always_comb begin
    ck_vec              = '0;
    ck_vec[N_CLK-1:0]   = ck_ok;
  end

  assign pick   = lowest_ok(ck_vec);
  assign cur_ok = src_ok(sel_q, ck_ok);
  assign tgt_ok = src_ok(tgt_q, ck_ok);
  assign req_ok = src_ok(req_sel, ck_ok);

  // ck_ok arrives from synchroniser flops, so qualifying ready with it keeps the
  // handshake honest in the cycle a failover pre-empts a request.
  assign fo_now    = AUTO && (state_q == ST_IDLE) && !cur_ok;
  assign req_ready = rdy_q && !fo_now;
  assign accept    = req_valid && req_ready;

  clk_mux_seq_tmr #(
    .CNT_W   (CNT_W),
    .RST_VAL (SETTLE_CYC)
  ) u_tmr (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .run      (tmr_run),
    .expire   (tmr_exp)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    tgt_d    = tgt_q;
    done_d   = 1'b0;
    rej_d    = 1'b0;
    fail_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = OFF_LD;
    tmr_run  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (fo_now) begin
          fail_d = 1'b1;
          if (pick.found) begin
            tgt_d    = SEL_W'(pick.idx);
            state_d  = ST_GATE_OFF;
            tmr_load = 1'b1;
            tmr_val  = OFF_LD;
          end else begin
            state_d = ST_HOLD;
          end
        end else if (accept) begin
          if (!req_ok) begin
            rej_d = 1'b1;
          end else if (req_sel == sel_q) begin
            done_d = 1'b1;
          end else begin
            tgt_d    = req_sel;
            state_d  = ST_GATE_OFF;
            tmr_load = 1'b1;
            tmr_val  = OFF_LD;
          end
        end
      end

      ST_GATE_OFF: begin
        tmr_run = 1'b1;
        if (tmr_exp) begin
          if (AUTO && !tgt_ok) begin
            if (pick.found) begin
              sel_d    = SEL_W'(pick.idx);
              state_d  = ST_SETTLE;
              tmr_load = 1'b1;
              tmr_val  = SET_LD;
            end else begin
              state_d = ST_HOLD;
            end
          end else begin
            sel_d    = tgt_q;
            state_d  = ST_SETTLE;
            tmr_load = 1'b1;
            tmr_val  = SET_LD;
          end
        end
      end

      ST_SETTLE: begin
        tmr_run = 1'b1;
        // Loss of the freshly selected source restarts settling on a new one.
        if (AUTO && !cur_ok) begin
          if (pick.found) begin
            sel_d    = SEL_W'(pick.idx);
            tmr_load = 1'b1;
            tmr_val  = SET_LD;
          end else begin
            state_d = ST_HOLD;
          end
        end else if (tmr_exp) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      ST_HOLD: begin
        if (pick.found) begin
          sel_d    = SEL_W'(pick.idx);
          state_d  = ST_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = SET_LD;
        end
      end

      default: begin
        state_d = ST_SETTLE;
      end
    endcase

    ce_d   = (state_d == ST_IDLE);
    busy_d = (state_d != ST_IDLE);
    rdy_d  = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_SETTLE;
      sel_q   <= RST_SEL_V;
      ce_q    <= 1'b0;
      busy_q  <= 1'b1;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      rej_q   <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ce_q    <= ce_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
      rej_q   <= rej_d;
      fail_q  <= fail_d;
    end
  end

  // The switch target is only read in GATE_OFF after being written, so it carries no reset.
  always_ff @(posedge clk) begin
    tgt_q <= tgt_d;
  end

  assign sel_out = sel_q;
  assign ce_out  = ce_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rej     = rej_q;
  assign fail    = fail_q;

endmodule

// File: tb/tb_clk_mux_seq.sv
// Self-checking bench for clk_mux_seq: directed timing sequences, a request
// vector table and randomized traffic against a remaining-cycles reference model.
module tb_clk_mux_seq;

  localparam int N   = 4;
  localparam int OFF = 8;
  localparam int SET = 16;
  localparam logic [3:0] ALL = 4'b1111;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic [1:0] req_sel;
  logic       req_ready;
  logic [3:0] ck_ok;
  logic [1:0] sel_out;
  logic       ce_out, busy, done, rej, fail;

  always #5 clk = ~clk;

  clk_mux_seq #(
    .N_CLK         (N),
    .OFF_CYC       (OFF),
    .SETTLE_CYC    (SET),
    .CNT_W         (8),
    .AUTO_FAILOVER (1),
    .RST_SEL       (0)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_sel   (req_sel),
    .req_ready (req_ready),
    .ck_ok     (ck_ok),
    .sel_out   (sel_out),
    .ce_out    (ce_out),
    .busy      (busy),
    .done      (done),
    .rej       (rej),
    .fail      (fail)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int since_sel = 0;

  // Reference model: remaining gate-off / settle cycles and a hold flag.
  int m_sel, m_tgt, gate_left, settle_left;
  bit hold, m_done, m_rej, m_fail;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lowest(input logic [3:0] ck);
    for (int i = 0; i < N; i++) if (ck[i]) return i;
    return -1;
  endfunction

  function automatic bit m_idle();
    return (gate_left == 0) && (settle_left == 0) && !hold;
  endfunction

  task automatic m_reset();
    m_sel = 0; m_tgt = 0; gate_left = 0; settle_left = SET; hold = 0;
    m_done = 0; m_rej = 0; m_fail = 0;
  endtask

  task automatic m_step(input logic [3:0] ck, input bit acc, input int rs);
    int lo;
    lo = lowest(ck);
    m_done = 0; m_rej = 0; m_fail = 0;
    if (m_idle()) begin
      if (!ck[m_sel]) begin
        m_fail = 1;
        if (lo >= 0) begin m_tgt = lo; gate_left = OFF; end
        else hold = 1;
      end else if (acc) begin
        if (rs >= N || !ck[rs]) m_rej = 1;
        else if (rs == m_sel) m_done = 1;
        else begin m_tgt = rs; gate_left = OFF; end
      end
    end else if (gate_left > 0) begin
      gate_left--;
      if (gate_left == 0) begin
        if (ck[m_tgt]) begin m_sel = m_tgt; settle_left = SET; end
        else if (lo >= 0) begin m_sel = lo; settle_left = SET; end
        else hold = 1;
      end
    end else if (settle_left > 0) begin
      if (!ck[m_sel]) begin
        if (lo >= 0) begin m_sel = lo; settle_left = SET; end
        else begin settle_left = 0; hold = 1; end
      end else begin
        settle_left--;
        if (settle_left == 0) m_done = 1;
      end
    end else if (lo >= 0) begin
      m_sel = lo; settle_left = SET; hold = 0;
    end
  endtask

  // One control-clock cycle: drive inputs, check ready, clock, check outputs.
  task automatic cycle(input logic [3:0] ck, input bit rv, input logic [1:0] rs);
    bit exp_rdy, prev_ce, was_rst;
    logic [1:0] prev_sel;
    logic [6:0] exp_o;
    ck_ok = ck; req_valid = rv; req_sel = rs;
    #1;
    exp_rdy = m_idle() && ck[m_sel];
    chk("req_ready", req_ready, exp_rdy);
    prev_ce = ce_out; prev_sel = sel_out; was_rst = !reset_n;
    if (was_rst) m_reset();
    else m_step(ck, rv && exp_rdy, int'(rs));
    @(posedge clk); #1;
    cyc++;
    exp_o = {2'(m_sel), m_idle(), !m_idle(), m_done, m_rej, m_fail};
    chk("model_outputs", {sel_out, ce_out, busy, done, rej, fail}, exp_o);
    if (was_rst || sel_out != prev_sel) since_sel = 0;
    else since_sel++;
    if (!was_rst && prev_ce) chk("sel_stable_while_ce", sel_out, prev_sel);
    if (!prev_ce && ce_out) chk("settle_gap", int'(since_sel >= SET), 1);
  endtask

  task automatic wait_idle(input logic [3:0] ck);
    int n;
    n = 0;
    while (!(ce_out && !busy) && n < 200) begin
      cycle(ck, 1'b0, 2'd0);
      n++;
    end
    if (n >= 200) chk("wait_idle_timeout", n, 0);
  endtask

  task automatic wait_sel(input logic [3:0] ck, input logic [1:0] s);
    int n;
    n = 0;
    while (sel_out != s && n < 200) begin
      cycle(ck, 1'b0, 2'd0);
      n++;
    end
    if (n >= 200) chk("wait_sel_timeout", n, 0);
  endtask

  task automatic wait_ce(input logic [3:0] ck);
    int n;
    n = 0;
    while (!ce_out && n < 200) begin
      cycle(ck, 1'b0, 2'd0);
      n++;
    end
    if (n >= 200) chk("wait_ce_timeout", n, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_sel"}, sel_out, 0);
    chk({tag, "_ce"}, ce_out, 0);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rej"}, rej, 0);
    chk({tag, "_fail"}, fail, 0);
  endtask

  typedef struct {
    logic [3:0] ck;
    logic [1:0] rs;
    bit         e_rej;
    bit         e_done;
    bit         e_busy;
    logic [1:0] e_sel;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int t, lo;
    logic [3:0] rck;

    tbl[0] = '{ALL,     2'd2, 1'b0, 1'b1, 1'b0, 2'd2};
    tbl[1] = '{4'b0111, 2'd3, 1'b1, 1'b0, 1'b0, 2'd2};
    tbl[2] = '{4'b1101, 2'd1, 1'b1, 1'b0, 1'b0, 2'd2};
    tbl[3] = '{ALL,     2'd0, 1'b0, 1'b0, 1'b1, 2'd0};
    tbl[4] = '{ALL,     2'd0, 1'b0, 1'b1, 1'b0, 2'd0};
    tbl[5] = '{4'b1011, 2'd2, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[6] = '{ALL,     2'd1, 1'b0, 1'b0, 1'b1, 2'd1};
    tbl[7] = '{ALL,     2'd2, 1'b0, 1'b0, 1'b1, 2'd2};

    reset_n = 1'b0; ck_ok = ALL; req_valid = 1'b0; req_sel = 2'd0;
    m_reset();
    @(posedge clk); @(posedge clk); #1;
    check_reset_vals("reset");

    // Out of reset: ce_out must first rise in cycle SETTLE_CYC+1.
    reset_n = 1'b1; cyc = 1; since_sel = 0;
    wait_ce(ALL);
    chk("reset_ce_rise_cycle", cyc, SET + 1);
    chk("reset_done_pulse", done, 1);

    // Real switch to source 2 with exact cycle offsets.
    t = cyc;
    cycle(ALL, 1'b1, 2'd2);
    chk("switch_ce_low", ce_out, 0);
    wait_sel(ALL, 2'd2);
    chk("switch_sel_cycle", cyc, t + OFF + 1);
    wait_ce(ALL);
    chk("switch_ce_cycle", cyc, t + OFF + SET + 1);
    chk("switch_done", done, 1);
    chk("switch_ready_again", req_ready, 1);

    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].ck, 1'b1, tbl[i].rs);
      chk($sformatf("tbl%0d_rej", i), rej, tbl[i].e_rej);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].e_done);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_ce", i), ce_out, !tbl[i].e_busy);
      wait_idle(ALL);
      chk($sformatf("tbl%0d_sel", i), sel_out, tbl[i].e_sel);
    end

    // Selected source 2 dies while a request for 3 is presented.
    t = cyc;
    cycle(4'b1010, 1'b1, 2'd3);
    chk("fo_fail_pulse", fail, 1);
    chk("fo_no_rej", rej, 0);
    chk("fo_ce_low", ce_out, 0);
    wait_sel(4'b1010, 2'd1);
    chk("fo_sel_cycle", cyc, t + OFF + 1);
    wait_idle(4'b1010);

    // No source healthy: HOLD until source 3 returns.
    cycle(4'b0000, 1'b0, 2'd0);
    chk("hold_fail_pulse", fail, 1);
    chk("hold_ce_low", ce_out, 0);
    repeat (5) cycle(4'b0000, 1'b0, 2'd0);
    chk("hold_busy", busy, 1);
    t = cyc;
    cycle(4'b1000, 1'b0, 2'd0);
    chk("hold_sel_3", sel_out, 3);
    wait_ce(4'b1000);
    chk("hold_ce_cycle", cyc, t + SET + 1);

    // Target loss during SETTLE retargets and restarts the settle time.
    cycle(ALL, 1'b1, 2'd0);
    wait_sel(ALL, 2'd0);
    repeat (4) cycle(ALL, 1'b0, 2'd0);
    t = cyc;
    cycle(4'b1110, 1'b0, 2'd0);
    chk("settle_retarget_sel", sel_out, 1);
    chk("settle_retarget_nofail", fail, 0);
    wait_ce(4'b1110);
    chk("settle_reload_cycle", cyc, t + SET + 1);

    // Reset during GATE_OFF.
    cycle(ALL, 1'b1, 2'd2);
    repeat (3) cycle(ALL, 1'b0, 2'd0);
    reset_n = 1'b0;
    cycle(ALL, 1'b0, 2'd0);
    check_reset_vals("midreset");
    reset_n = 1'b1;
    wait_idle(ALL);

    rck = ALL;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) rck = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 19) == 0) rck = ALL;
      reset_n = ($urandom_range(0, 399) != 0);
      lo = $urandom_range(0, 3);
      cycle(rck, ($urandom_range(0, 3) == 0), 2'(lo));
    end
    reset_n = 1'b1;
    wait_idle(ALL);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
